yl3_rx: RTL and testbench
=========================

Name: yl3_rx

Overview:
Receive-side counterpart of the YL-3 8-digit 74HC595 display link. It samples the three-wire serial stream (sda, sclk, slatch) and decodes each 16-bit frame into {position one-hot, active-low segment byte}. It keeps a shadow copy of all eight digits, so the display driver output can be checked in loopback on the FPGA and a bench has a monitor for it. Malformed frames are flagged; they are never applied.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each of sda/sclk/slatch before edge detection (min 2).
TIMEOUT_CYC, 1024, clk cycles with no sclk/slatch edge after which a partial frame is discarded (min 2).

Ports:
clk  input  1  system clock (50 MHz).
rst  input  1  asynchronous active-high reset.
sda  input  1  serial data, asynchronous to clk.
sclk  input  1  shift clock, asynchronous; data sampled on rising edge.
slatch  input  1  latch, asynchronous; frame committed on rising edge.
err_clr  input  1  one-cycle pulse; clears sticky error flags.
digits  output  64  shadow display; digit k segment byte at [63-8k : 56-8k], active-low (.GFEDCBA).
frame_stb  output  1  one-cycle pulse per accepted frame.
frame_pos  output  3  digit index of last accepted frame.
frame_seg  output  8  segment byte of last accepted frame.
scan_done  output  1  one-cycle pulse when all 8 digits have been written since the previous scan_done/reset.
err_len  output  1  sticky; a latch arrived with bit count != 16.
err_pos  output  1  sticky; a 16-bit frame had a non-one-hot position byte.
err_tmo  output  1  sticky; partial frame aborted by timeout.

Behaviour:
- Reset (async assert, sync release on clk): digits = 64'hFFFF_FFFF_FFFF_FFFF (all blank); frame_pos = 0; frame_seg = 8'hFF; all strobes and errors = 0; shreg = 0; bitcnt = 0; seen mask = 0; timer = 0.
- Sync: each input passes through SYNC_STAGES flops. Edge = synced value high while previous synced value low. sda sampling uses the synced copy, which has the same delay as sclk.
- Shift: on sclk edge, shreg <= {shreg[14:0], sda_s}. bitcnt increments and saturates at 31. The first bit received is the frame MSB (position bit 7).
- Frame layout: shreg[15:8] = position one-hot (bit i selects digit i), shreg[7:0] = segment byte.
- Commit on slatch edge, in priority order:
  1. bitcnt != 16: err_len <= 1, nothing applied.
  2. Position byte not exactly one bit set (including 0): err_pos <= 1, nothing applied.
  3. Otherwise: write digit i, frame_pos <= i, frame_seg <= byte, frame_stb = 1 for one cycle, seen[i] <= 1.
  - In all three cases bitcnt <= 0 and the timer is cleared. shreg is not cleared.
- Simultaneous sclk and slatch edges in one cycle: the shift applies first, and the commit evaluates the post-shift shreg and bitcnt+1.
- scan_done: the cycle after seen becomes 8'hFF, scan_done pulses and seen is cleared. Rewriting an already-seen digit has no effect on seen.
- Timeout: when bitcnt != 0, the timer counts clk cycles without any sclk/slatch edge. At TIMEOUT_CYC: bitcnt <= 0, err_tmo <= 1, timer <= 0. The timer is idle when bitcnt == 0.
- err_clr clears all three flags. If err_clr and a new error occur in the same cycle, the new error flag is set.
- Latency: digits, frame_* and frame_stb update on the cycle after the synced slatch edge, i.e. SYNC_STAGES+1 clk after the raw edge. No backpressure.
- A latch with no preceding bits (bitcnt = 0) sets err_len.
- Minimum input phase width is 2 clk cycles; faster streams are out of spec.

Test Plan:
- After reset, digits = all FF and all flags = 0. Send 16 bits 0x01C0, then latch: frame_stb once, frame_pos = 0, frame_seg = C0, digits[63:56] = C0, rest FF.
- Send 8 frames 0x01F9, 0x02A4, …, 0x8080 (positions 0–7): 8 frame_stb pulses; scan_done pulses exactly once, one cycle after the 8th; digits = F9A4B0999282F880.
- 15 bits then latch: err_len = 1, digits unchanged. Then send err_clr → err_len = 0. Then a good frame is accepted normally.
- Frame 0x0392 (two position bits): err_pos = 1, no frame_stb. Frame 0x0092: err_pos = 1, no frame_stb.
- 7 bits then idle for TIMEOUT_CYC: err_tmo = 1 and bitcnt is reset. The next 16-bit frame 0x1086 writes digit 4 = 86.
- Assert rst mid-frame after 9 bits: everything returns to reset values immediately. The next full frame is accepted, with no err_len.

Source files
------------

// File: rtl/yl3_rx.sv
// YL-3 display link receiver: samples sda/sclk/slatch, decodes 16-bit
// {position one-hot, segment byte} frames into an eight-digit shadow display.
module yl3_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sda,
  input  logic        sclk,
  input  logic        slatch,
  input  logic        err_clr,
  output logic [63:0] digits,
  output logic        frame_stb,
  output logic [2:0]  frame_pos,
  output logic [7:0]  frame_seg,
  output logic        scan_done,
  output logic        err_len,
  output logic        err_pos,
  output logic        err_tmo
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] sda_sy, sclk_sy, slat_sy;
  logic        sclk_q, slat_q;
  logic [15:0] shreg, sh_nx;
  logic [4:0]  bitcnt, cnt_nx;
  logic [TW-1:0] timer;
  logic [7:0]  seen;
  logic        sda_s, sclk_e, slat_e;
  logic [2:0]  pos_idx;
  logic        len_bad, pos_bad, accept, tmo;

  assign sda_s  = sda_sy[SYNC_STAGES-1];
  assign sclk_e = sclk_sy[SYNC_STAGES-1] & ~sclk_q;
  assign slat_e = slat_sy[SYNC_STAGES-1] & ~slat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_sy  <= '0;
      sclk_sy <= '0;
      slat_sy <= '0;
      sclk_q  <= 1'b0;
      slat_q  <= 1'b0;
    end else begin
      sda_sy  <= {sda_sy[SYNC_STAGES-2:0], sda};
      sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk};
      slat_sy <= {slat_sy[SYNC_STAGES-2:0], slatch};
      sclk_q  <= sclk_sy[SYNC_STAGES-1];
      slat_q  <= slat_sy[SYNC_STAGES-1];
    end
  end

  // A latch in the same cycle as a shift judges the post-shift frame.
  always_comb begin
    sh_nx   = sclk_e ? {shreg[14:0], sda_s} : shreg;
    cnt_nx  = (sclk_e && bitcnt != 5'd31) ? bitcnt + 5'd1 : bitcnt;
    pos_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (sh_nx[8+i]) pos_idx = 3'(i);
    len_bad = slat_e && (cnt_nx != 5'd16);
    pos_bad = slat_e && !len_bad && !$onehot(sh_nx[15:8]);
    accept  = slat_e && !len_bad && !pos_bad;
    tmo     = (bitcnt != 5'd0) && !sclk_e && !slat_e && (timer == TW'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      bitcnt    <= '0;
      timer     <= '0;
      seen      <= '0;
      digits    <= '1;
      frame_stb <= 1'b0;
      frame_pos <= '0;
      frame_seg <= 8'hFF;
      scan_done <= 1'b0;
      err_len   <= 1'b0;
      err_pos   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      shreg     <= sh_nx;
      bitcnt    <= (slat_e || tmo) ? 5'd0 : cnt_nx;
      if (bitcnt == 5'd0 || sclk_e || slat_e || tmo) timer <= '0;
      else                                           timer <= timer + TW'(1);
      frame_stb <= accept;
      if (accept) begin
        digits[{3'd7 - pos_idx, 3'b000} +: 8] <= sh_nx[7:0];
        frame_pos <= pos_idx;
        frame_seg <= sh_nx[7:0];
      end
      // scan_done fires the cycle after the mask fills; the mask then restarts.
      scan_done <= (seen == 8'hFF);
      if (seen == 8'hFF) seen <= accept ? (8'd1 << pos_idx) : 8'd0;
      else if (accept)   seen <= seen | (8'd1 << pos_idx);
      err_len <= (err_len & ~err_clr) | len_bad;
      err_pos <= (err_pos & ~err_clr) | pos_bad;
      err_tmo <= (err_tmo & ~err_clr) | tmo;
    end
  end
endmodule

// File: tb/tb_yl3_rx.sv
// Bench for yl3_rx: drives serial frames, scoreboards accepted frames and
// checks the shadow display and error flags per scenario.
module tb_yl3_rx;
  localparam int SS  = 2;
  localparam int TMO = 64;

  logic        clk = 1'b0, rst = 1'b0;
  logic        sda = 1'b0, sclk = 1'b0, slatch = 1'b0, err_clr = 1'b0;
  logic [63:0] digits;
  logic        frame_stb, scan_done, err_len, err_pos, err_tmo;
  logic [2:0]  frame_pos;
  logic [7:0]  frame_seg;

  yl3_rx #(.SYNC_STAGES(SS), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .sda(sda), .sclk(sclk), .slatch(slatch),
    .err_clr(err_clr), .digits(digits), .frame_stb(frame_stb),
    .frame_pos(frame_pos), .frame_seg(frame_seg), .scan_done(scan_done),
    .err_len(err_len), .err_pos(err_pos), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] pos; logic [7:0] seg; } exp_t;
  exp_t        q[$];
  logic [63:0] exp_digits = '1;
  int checks = 0, errors = 0;
  int cyc_n = 0, stb_cnt = 0, scan_cnt = 0, last_stb = 0, scan_cyc = 0;

  // Scoreboard: every accepted frame must match the next expected entry.
  always @(negedge clk) begin
    cyc_n++;
    if (frame_stb) begin
      exp_t e;
      stb_cnt++;
      last_stb = cyc_n;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_stb: got pos=%0d seg=%h, expected no frame", frame_pos, frame_seg);
      end else begin
        e = q.pop_front();
        if (frame_pos !== e.pos || frame_seg !== e.seg) begin
          errors++;
          $display("FAIL frame: got pos=%0d seg=%h, expected pos=%0d seg=%h", frame_pos, frame_seg, e.pos, e.seg);
        end
      end
    end
    if (scan_done) begin
      scan_cnt++;
      scan_cyc = cyc_n;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sda = w[i];
      cyc(2);
      sclk = 1'b1;
      cyc(3);
      sclk = 1'b0;
      cyc(2);
    end
  endtask

  task automatic do_latch();
    slatch = 1'b1;
    cyc(3);
    slatch = 1'b0;
    cyc(4);
  endtask

  task automatic send_frame(input logic [15:0] w, input bit good);
    exp_t e;
    if (good) begin
      e.pos = 3'd0;
      for (int i = 0; i < 8; i++) if (w[8+i]) e.pos = 3'(i);
      e.seg = w[7:0];
      q.push_back(e);
      exp_digits[{3'd7 - e.pos, 3'b000} +: 8] = w[7:0];
    end
    send_bits(w, 16);
    do_latch();
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected frames never strobed, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    @(negedge clk);
    checks++;
    if (digits !== 64'hFFFF_FFFF_FFFF_FFFF || frame_pos !== 3'd0 || frame_seg !== 8'hFF ||
        {frame_stb, scan_done, err_len, err_pos, err_tmo} !== 5'b0) begin
      errors++;
      $display("FAIL reset: digits=%h pos=%0d seg=%h flags=%b, required all-FF/0/FF/00000",
               digits, frame_pos, frame_seg, {frame_stb, scan_done, err_len, err_pos, err_tmo});
    end
  endtask

  task automatic test_single();
    int s0 = stb_cnt;
    send_frame(16'h01C0, 1'b1);
    check_queue_empty("single_stb");
    checks++;
    if (stb_cnt - s0 != 1) begin
      errors++; $display("FAIL single_count: %0d strobes, required 1", stb_cnt - s0);
    end
    checks++;
    if (digits !== 64'hC0FF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL single_digits: got %h, required C0FFFFFFFFFFFFFF", digits);
    end
  endtask

  task automatic test_scan();
    logic [15:0] f[8] = '{16'h01F9, 16'h02A4, 16'h04B0, 16'h0899,
                          16'h1092, 16'h2082, 16'h40F8, 16'h8080};
    int s0 = stb_cnt, c0 = scan_cnt;
    foreach (f[i]) send_frame(f[i], 1'b1);
    check_queue_empty("scan_stb");
    checks++;
    if (stb_cnt - s0 != 8) begin
      errors++; $display("FAIL scan_stb_count: %0d, required 8", stb_cnt - s0);
    end
    checks++;
    if (scan_cnt - c0 != 1 || scan_cyc != last_stb + 1) begin
      errors++;
      $display("FAIL scan_done: %0d pulses at +%0d cycles, required 1 at +1", scan_cnt - c0, scan_cyc - last_stb);
    end
    checks++;
    if (digits !== 64'hF9A4_B099_9282_F880) begin
      errors++; $display("FAIL scan_digits: got %h, required F9A4B0999282F880", digits);
    end
  endtask

  task automatic test_err_len();
    int s0 = stb_cnt;
    send_bits(16'h01C0, 15);
    do_latch();
    checks++;
    if (err_len !== 1'b1 || digits !== exp_digits || stb_cnt != s0) begin
      errors++;
      $display("FAIL err_len_set: err_len=%b digits=%h strobes=%0d, required 1 %h 0", err_len, digits, stb_cnt - s0, exp_digits);
    end
    clear_errs();
    checks++;
    if (err_len !== 1'b0) begin
      errors++; $display("FAIL err_len_clr: got %b, required 0", err_len);
    end
    send_frame(16'h04C6, 1'b1);
    check_queue_empty("after_len_stb");
    checks++;
    if (digits !== exp_digits || err_len !== 1'b0) begin
      errors++; $display("FAIL after_len: digits=%h err_len=%b, required %h 0", digits, err_len, exp_digits);
    end
    // Latch with no bits at all.
    do_latch();
    checks++;
    if (err_len !== 1'b1) begin
      errors++; $display("FAIL empty_latch: err_len=%b, required 1", err_len);
    end
    clear_errs();
  endtask

  task automatic test_err_pos();
    int s0 = stb_cnt;
    send_frame(16'h0392, 1'b0);
    checks++;
    if (err_pos !== 1'b1 || err_len !== 1'b0 || stb_cnt != s0 || digits !== exp_digits) begin
      errors++;
      $display("FAIL pos_two: err_pos=%b err_len=%b strobes=%0d digits=%h, required 1 0 0 %h", err_pos, err_len, stb_cnt - s0, digits, exp_digits);
    end
    clear_errs();
    send_frame(16'h0092, 1'b0);
    checks++;
    if (err_pos !== 1'b1 || stb_cnt != s0 || digits !== exp_digits) begin
      errors++;
      $display("FAIL pos_zero: err_pos=%b strobes=%0d digits=%h, required 1 0 %h", err_pos, stb_cnt - s0, digits, exp_digits);
    end
    clear_errs();
  endtask

  task automatic test_timeout();
    send_bits(16'h0055, 7);
    cyc(TMO + 10);
    @(negedge clk);
    checks++;
    if (err_tmo !== 1'b1 || err_len !== 1'b0) begin
      errors++; $display("FAIL timeout: err_tmo=%b err_len=%b, required 1 0", err_tmo, err_len);
    end
    send_frame(16'h1086, 1'b1);
    check_queue_empty("after_tmo_stb");
    checks++;
    if (err_len !== 1'b0 || digits[31:24] !== 8'h86 || digits !== exp_digits) begin
      errors++; $display("FAIL after_tmo: err_len=%b digits=%h, required 0 %h", err_len, digits, exp_digits);
    end
    clear_errs();
  endtask

  task automatic test_reset_midframe();
    int s0;
    send_bits(16'h01FF, 9);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (digits !== 64'hFFFF_FFFF_FFFF_FFFF || frame_seg !== 8'hFF || frame_pos !== 3'd0 ||
        {err_len, err_pos, err_tmo, frame_stb, scan_done} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: digits=%h seg=%h pos=%0d flags=%b, required reset values", digits, frame_seg, frame_pos,
               {err_len, err_pos, err_tmo, frame_stb, scan_done});
    end
    exp_digits = '1;
    q.delete();
    cyc(2);
    rst = 1'b0;
    cyc(2);
    s0 = stb_cnt;
    send_frame(16'h2024, 1'b1);
    check_queue_empty("post_reset_stb");
    checks++;
    if (err_len !== 1'b0 || stb_cnt - s0 != 1 || digits !== exp_digits) begin
      errors++;
      $display("FAIL post_reset: err_len=%b strobes=%0d digits=%h, required 0 1 %h", err_len, stb_cnt - s0, digits, exp_digits);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan();
    test_err_len();
    test_err_pos();
    test_timeout();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
